marker_scheduler: RTL and testbench
===================================

MARKER_SCHEDULER -- requirements
Module: marker_scheduler

Interface
REQ-001 SHALL have parameter NUM_MARKERS, default 5, meaning number of tracked colour markers (slot 0..3 hands LB/LT/RB/RT, slot 4 head).
REQ-002 SHALL have parameter IDX_W, default 3, meaning width of slot index (ceil log2 NUM_MARKERS).
REQ-003 clk_in  input  1  pixel clock (65 MHz); all state on rising edge.
REQ-004 rst_in  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 enable_in  input  1  run scheduling when 1.
REQ-006 frame_start_in  input  1  single-cycle pulse at hcount==0 && vcount==0.
REQ-007 cfg_we_in  input  1  config table write strobe.
REQ-008 cfg_idx_in  input  IDX_W  config slot to write.
REQ-009 cfg_data_in  input  9  {upper[2:0], lower[2:0], sel[2:0]} threshold settings.
REQ-010 com_x_in  input  11  centre-of-mass x result.
REQ-011 com_y_in  input  10  centre-of-mass y result.
REQ-012 com_valid_in  input  1  one-cycle result strobe from centre-of-mass unit.
REQ-013 sel_out  output  3  threshold channel select for active slot.
REQ-014 lower_out / upper_out  output  3 each  threshold bounds for active slot.
REQ-015 tabulate_out  output  1  one-cycle pulse closing the centre-of-mass accumulation.
REQ-016 active_idx_out  output  IDX_W  slot currently being thresholded.
REQ-017 markers_x_out  output  11*NUM_MARKERS  packed x per slot, slot k at [11k+10:11k].
REQ-018 markers_y_out  output  10*NUM_MARKERS  packed y per slot, slot k at [10k+9:10k].
REQ-019 found_out  output  NUM_MARKERS  bit k = slot k holds a result from its latest scheduled frame.
REQ-020 round_done_out  output  1  one-cycle pulse when the last slot's frame is resolved.

Function
REQ-021 All outputs SHALL be registered; sel/lower/upper SHALL equal the config entry of active_idx_out.
REQ-022 FSM states SHALL be IDLE, ARM, SCAN, WAIT_RES.
REQ-023 IDLE: active_idx=0, no tabulate; enable_in=1 -> ARM.
REQ-024 ARM: on frame_start_in, tabulate_out pulses next cycle (flushes partial frame), active_idx stays 0, -> SCAN; that flush's com_valid_in SHALL be ignored.
REQ-025 SCAN: com_valid_in ignored; on frame_start_in: tabulate_out pulses next cycle, pend_idx<=active_idx, active_idx<=active_idx+1 wrapping NUM_MARKERS-1 -> 0, -> WAIT_RES.
REQ-026 WAIT_RES, com_valid_in without frame_start_in: next cycle slot pend_idx x/y <= com_x_in/com_y_in, found[pend_idx]<=1, -> SCAN.
REQ-027 WAIT_RES, frame_start_in without prior com_valid_in (miss): found[pend_idx]<=0, coordinates retained, then act as REQ-025 but remain in WAIT_RES.
REQ-028 WAIT_RES, com_valid_in and frame_start_in same cycle: capture result for old pend_idx (REQ-026), then apply REQ-025 advance, remain in WAIT_RES.
REQ-029 round_done_out SHALL pulse in the cycle pend_idx==NUM_MARKERS-1 is resolved (capture or miss).
REQ-030 enable_in=0 in any state SHALL force IDLE next cycle, active_idx=0, no tabulate; results and found_out retained.
REQ-031 Config writes SHALL take effect next cycle; cfg_idx_in>=NUM_MARKERS SHALL be ignored; writing the active slot SHALL change sel/lower/upper next cycle.
REQ-032 Latency: tabulate_out and new active config 1 cycle after frame_start_in; result 1 cycle after com_valid_in.

Reset
REQ-033 rst_in=0 SHALL asynchronously force IDLE, active_idx=0, pend_idx=0, tabulate_out=0, round_done_out=0, all coordinates 0, found_out=0.
REQ-034 Config table reset value SHALL be sel=0, lower=0, upper=7 for every slot.
REQ-035 Reset mid-WAIT_RES SHALL discard pending result; first post-reset com_valid_in SHALL not be captured.

Verification
REQ-036 Reset, enable=1, 6 frame_starts each followed 100 cycles later by com_valid (x=10k, y=5k for frame k) -> slot k-2 gets (10k,5k) for k=2..6 (flush frame 1 ignored, frame k result lands in slot k-2), found=5'b11111, round_done once.
REQ-037 Omit com_valid after slot 2 frame -> found[2]=0, slot 2 coords unchanged, scheduling continues to slot 3.
REQ-038 com_valid and frame_start same cycle in WAIT_RES -> result captured for old slot and tabulate_out pulses next cycle.
REQ-039 Write cfg slot 1 = {3'd6,3'd2,3'd4} while slot 1 active -> sel=4, lower=2, upper=6 next cycle; write idx 7 -> no change.
REQ-040 enable_in low mid-WAIT_RES -> IDLE, active_idx=0, coords kept; rst_in low -> all outputs to REQ-033 values immediately without clock.

Source files
------------

// File: rtl/marker_scheduler.sv
// Round-robin scheduler that steps the colour thresholder through each marker slot one
// frame at a time and files each centre-of-mass result under the slot that produced it.
module marker_scheduler #(
    parameter int NUM_MARKERS = 5,
    parameter int IDX_W       = 3
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      enable_in,
    input  logic                      frame_start_in,
    input  logic                      cfg_we_in,
    input  logic [IDX_W-1:0]          cfg_idx_in,
    input  logic [8:0]                cfg_data_in,
    input  logic [10:0]               com_x_in,
    input  logic [9:0]                com_y_in,
    input  logic                      com_valid_in,
    output logic [2:0]                sel_out,
    output logic [2:0]                lower_out,
    output logic [2:0]                upper_out,
    output logic                      tabulate_out,
    output logic [IDX_W-1:0]          active_idx_out,
    output logic [11*NUM_MARKERS-1:0] markers_x_out,
    output logic [10*NUM_MARKERS-1:0] markers_y_out,
    output logic [NUM_MARKERS-1:0]    found_out,
    output logic                      round_done_out
);

    typedef enum logic [1:0] {IDLE, ARM, SCAN, WAIT_RES} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MARKERS - 1);
    localparam logic [8:0]       CFG_RESET = 9'b111_000_000;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             active_q, active_d, pend_q, pend_d, next_idx;
    logic                         tab_d, done_d, advance, capture, miss, cfg_ok;
    logic [8:0]                   cfg_q [NUM_MARKERS];
    logic [8:0]                   cfg_entry_d;
    logic [NUM_MARKERS-1:0][10:0] x_q;
    logic [NUM_MARKERS-1:0][9:0]  y_q;
    logic [NUM_MARKERS-1:0]       found_q;

    assign next_idx = (active_q == LAST_IDX) ? '0 : active_q + 1'b1;
    assign cfg_ok   = cfg_we_in && (cfg_idx_in <= LAST_IDX);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        tab_d    = 1'b0;
        done_d   = 1'b0;
        advance  = 1'b0;
        capture  = 1'b0;
        miss     = 1'b0;
        if (!enable_in) begin
            state_d  = IDLE;
            active_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    active_d = '0;
                    state_d  = ARM;
                end
                // The first tabulate only flushes a partial frame; its result is never kept.
                ARM: if (frame_start_in) begin
                    tab_d   = 1'b1;
                    state_d = SCAN;
                end
                SCAN: if (frame_start_in) begin
                    advance = 1'b1;
                    state_d = WAIT_RES;
                end
                WAIT_RES: begin
                    capture = com_valid_in;
                    miss    = frame_start_in && !com_valid_in;
                    done_d  = (capture || miss) && (pend_q == LAST_IDX);
                    if (frame_start_in) advance = 1'b1;
                    else if (com_valid_in) state_d = SCAN;
                end
                default: state_d = IDLE;
            endcase
        end
        if (advance) begin
            tab_d    = 1'b1;
            pend_d   = active_q;
            active_d = next_idx;
        end
        // A write to the slot about to be active bypasses the table so the outputs follow at once.
        cfg_entry_d = (cfg_ok && cfg_idx_in == active_d) ? cfg_data_in : cfg_q[active_d];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= IDLE;
            active_q       <= '0;
            pend_q         <= '0;
            tabulate_out   <= 1'b0;
            round_done_out <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            pend_q         <= pend_d;
            tabulate_out   <= tab_d;
            round_done_out <= done_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            // NOTE: the config table is tiny and has defined power-on thresholds, so it is reset too.
            for (int k = 0; k < NUM_MARKERS; k++) cfg_q[k] <= CFG_RESET;
            x_q                              <= '0;
            y_q                              <= '0;
            found_q                          <= '0;
            {upper_out, lower_out, sel_out}  <= CFG_RESET;
        end else begin
            if (cfg_ok) cfg_q[cfg_idx_in] <= cfg_data_in;
            if (capture) begin
                x_q[pend_q]     <= com_x_in;
                y_q[pend_q]     <= com_y_in;
                found_q[pend_q] <= 1'b1;
            end
            if (miss) found_q[pend_q] <= 1'b0;
            {upper_out, lower_out, sel_out} <= cfg_entry_d;
        end
    end

    assign active_idx_out = active_q;
    assign markers_x_out  = x_q;
    assign markers_y_out  = y_q;
    assign found_out      = found_q;

endmodule

// File: tb/tb_marker_scheduler.sv
// Randomised scoreboard bench for marker_scheduler: a frame-level reference model predicts
// each tabulate and round-done pulse, and a monitor compares them as the DUT produces them.
module tb_marker_scheduler;

    localparam int N = 5;
    localparam int P_IDLE = 0, P_ARM = 1, P_SCAN = 2, P_WAIT = 3;

    logic        clk_in = 1'b0;
    logic        rst_in, enable_in, frame_start_in, cfg_we_in, com_valid_in;
    logic [2:0]  cfg_idx_in;
    logic [8:0]  cfg_data_in;
    logic [10:0] com_x_in;
    logic [9:0]  com_y_in;
    logic [2:0]  sel_out, lower_out, upper_out, active_idx_out;
    logic        tabulate_out, round_done_out;
    logic [54:0] markers_x_out;
    logic [49:0] markers_y_out;
    logic [4:0]  found_out;

    marker_scheduler #(.NUM_MARKERS(N), .IDX_W(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .frame_start_in(frame_start_in), .cfg_we_in(cfg_we_in), .cfg_idx_in(cfg_idx_in),
        .cfg_data_in(cfg_data_in), .com_x_in(com_x_in), .com_y_in(com_y_in),
        .com_valid_in(com_valid_in), .sel_out(sel_out), .lower_out(lower_out),
        .upper_out(upper_out), .tabulate_out(tabulate_out), .active_idx_out(active_idx_out),
        .markers_x_out(markers_x_out), .markers_y_out(markers_y_out), .found_out(found_out),
        .round_done_out(round_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [2:0] idx; logic [8:0] cfg; } tab_t;
    typedef struct { logic [4:0] found; logic [54:0] x; logic [49:0] y; } rd_t;
    tab_t tab_q[$];
    rd_t  rd_q[$];

    int n_checks = 0, n_fail = 0, rd_count = 0;

    int          m_phase, m_active, m_pend;
    logic [10:0] m_x [N];
    logic [9:0]  m_y [N];
    logic [4:0]  m_found;
    logic [8:0]  m_cfg [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [54:0] pack_x();
        logic [54:0] v;
        for (int k = 0; k < N; k++) v[11*k +: 11] = m_x[k];
        return v;
    endfunction

    function automatic logic [49:0] pack_y();
        logic [49:0] v;
        for (int k = 0; k < N; k++) v[10*k +: 10] = m_y[k];
        return v;
    endfunction

    function automatic logic [10:0] slot_x(input int k);
        logic [54:0] v = markers_x_out;
        return v[11*k +: 11];
    endfunction

    function automatic logic [9:0] slot_y(input int k);
        logic [49:0] v = markers_y_out;
        return v[10*k +: 10];
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_active = 0; m_pend = 0; m_found = '0;
        for (int k = 0; k < N; k++) begin
            m_x[k] = '0; m_y[k] = '0; m_cfg[k] = 9'b111_000_000;
        end
    endtask

    task automatic model_resolved();
        rd_t r;
        if (m_pend == N - 1) begin
            r.found = m_found; r.x = pack_x(); r.y = pack_y();
            rd_q.push_back(r);
        end
    endtask

    task automatic push_tab();
        tab_t t;
        t.idx = 3'(m_active); t.cfg = m_cfg[m_active];
        tab_q.push_back(t);
    endtask

    task automatic model_advance();
        m_pend   = m_active;
        m_active = (m_active + 1) % N;
        push_tab();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic frame_start(input bit with_valid, input logic [10:0] x, input logic [9:0] y);
        @(negedge clk_in);
        frame_start_in = 1'b1; com_valid_in = with_valid; com_x_in = x; com_y_in = y;
        case (m_phase)
            P_ARM:  begin push_tab(); m_phase = P_SCAN; end
            P_SCAN: begin model_advance(); m_phase = P_WAIT; end
            P_WAIT: begin
                if (with_valid) begin
                    m_x[m_pend] = x; m_y[m_pend] = y; m_found[m_pend] = 1'b1;
                end else begin
                    m_found[m_pend] = 1'b0;
                end
                model_resolved();
                model_advance();
            end
            default: ;
        endcase
        @(negedge clk_in);
        frame_start_in = 1'b0; com_valid_in = 1'b0;
    endtask

    task automatic com_valid(input logic [10:0] x, input logic [9:0] y);
        @(negedge clk_in);
        com_valid_in = 1'b1; com_x_in = x; com_y_in = y;
        if (m_phase == P_WAIT) begin
            m_x[m_pend] = x; m_y[m_pend] = y; m_found[m_pend] = 1'b1;
            model_resolved();
            m_phase = P_SCAN;
        end
        @(negedge clk_in);
        com_valid_in = 1'b0;
        check("result_x", markers_x_out, pack_x());
        check("result_y", markers_y_out, pack_y());
        check("result_found", found_out, m_found);
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [8:0] data);
        @(negedge clk_in);
        cfg_we_in = 1'b1; cfg_idx_in = idx; cfg_data_in = data;
        if (idx < N) m_cfg[idx] = data;
        @(negedge clk_in);
        cfg_we_in = 1'b0;
        check("cfg_out", {upper_out, lower_out, sel_out}, m_cfg[m_active]);
    endtask

    task automatic enable_drop();
        @(negedge clk_in);
        enable_in = 1'b0;
        @(negedge clk_in);
        enable_in = 1'b1;
        m_active = 0;
        check("idle_active", active_idx_out, 0);
        check("idle_tab", tabulate_out, 0);
        check("idle_cfg", {upper_out, lower_out, sel_out}, m_cfg[0]);
        check("idle_x_kept", markers_x_out, pack_x());
        check("idle_found_kept", found_out, m_found);
        m_phase = P_ARM;
    endtask

    task automatic reset_dut();
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        check("rst_tab", tabulate_out, 0);
        check("rst_done", round_done_out, 0);
        check("rst_active", active_idx_out, 0);
        check("rst_x", markers_x_out, 0);
        check("rst_y", markers_y_out, 0);
        check("rst_found", found_out, 0);
        check("rst_cfg", {upper_out, lower_out, sel_out}, 9'b111_000_000);
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        m_phase = enable_in ? P_ARM : P_IDLE;
    endtask

    initial begin : monitor
        tab_t t;
        rd_t  r;
        forever begin
            @(negedge clk_in);
            if (rst_in === 1'b1 && tabulate_out === 1'b1) begin
                if (tab_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tab_unexpected: got pulse, expected none (t=%0t)", $time);
                end else begin
                    t = tab_q.pop_front();
                    check("tab_active", active_idx_out, t.idx);
                    check("tab_cfg", {upper_out, lower_out, sel_out}, t.cfg);
                end
            end
            if (rst_in === 1'b1 && round_done_out === 1'b1) begin
                rd_count++;
                if (rd_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL done_unexpected: got pulse, expected none (t=%0t)", $time);
                end else begin
                    r = rd_q.pop_front();
                    check("done_found", found_out, r.found);
                    check("done_x", markers_x_out, r.x);
                    check("done_y", markers_y_out, r.y);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [10:0] rx;
        logic [9:0]  ry;
        rst_in = 1'b1; enable_in = 1'b0; frame_start_in = 1'b0; cfg_we_in = 1'b0;
        cfg_idx_in = '0; cfg_data_in = '0; com_x_in = '0; com_y_in = '0; com_valid_in = 1'b0;
        model_reset();
        reset_dut();
        @(negedge clk_in);
        enable_in = 1'b1;
        m_phase = P_ARM;

        // Six frames: flush frame ignored, frame k result lands in slot k-2.
        for (int k = 1; k <= 6; k++) begin
            frame_start(1'b0, '0, '0);
            tick(99);
            com_valid(11'(10 * k), 10'(5 * k));
        end
        for (int k = 2; k <= 6; k++) begin
            check($sformatf("slot%0d_x", k - 2), slot_x(k - 2), 10 * k);
            check($sformatf("slot%0d_y", k - 2), slot_y(k - 2), 5 * k);
        end
        check("found_all", found_out, 5'b11111);
        check("round_done_once", rd_count, 1);

        // Missed result for slot 2.
        frame_start(1'b0, '0, '0); com_valid(11'd111, 10'd222);
        frame_start(1'b0, '0, '0); com_valid(11'd333, 10'd444);
        frame_start(1'b0, '0, '0); tick(20);
        frame_start(1'b0, '0, '0);
        check("miss_found2", found_out[2], 1'b0);
        check("miss_x2_kept", slot_x(2), 40);
        check("miss_y2_kept", slot_y(2), 20);
        check("miss_next_active", active_idx_out, 4);
        com_valid(11'd555, 10'd666);

        // Result and next frame start in the same cycle.
        frame_start(1'b0, '0, '0);
        frame_start(1'b1, 11'd1234, 10'd777);
        check("same_cycle_x4", slot_x(4), 1234);
        check("same_cycle_y4", slot_y(4), 777);
        com_valid(11'd7, 10'd9);

        // Live config write to the active slot, then an out-of-range write.
        cfg_write(3'd1, {3'd6, 3'd2, 3'd4});
        check("cfg_sel", sel_out, 4);
        check("cfg_lower", lower_out, 2);
        check("cfg_upper", upper_out, 6);
        cfg_write(3'd7, 9'h1FF);
        check("cfg_idx7_ignored", {upper_out, lower_out, sel_out}, {3'd6, 3'd2, 3'd4});

        // Disable while waiting for a result, then reset while waiting.
        frame_start(1'b0, '0, '0);
        enable_drop();
        frame_start(1'b0, '0, '0);
        frame_start(1'b0, '0, '0);
        reset_dut();
        com_valid(11'd99, 10'd99);
        check("post_reset_found", found_out, 0);

        for (int i = 0; i < 60; i++) begin
            rx = 11'($urandom_range(0, 2047));
            ry = 10'($urandom_range(0, 1023));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    frame_start(1'b0, '0, '0);
                    if ($urandom_range(0, 3) != 0) begin
                        tick($urandom_range(0, 8));
                        com_valid(rx, ry);
                    end
                end
                6: frame_start(1'b1, rx, ry);
                7: cfg_write(3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)));
                8: enable_drop();
                default: tick($urandom_range(1, 5));
            endcase
        end

        tick(3);
        check("tab_queue_drained", tab_q.size(), 0);
        check("done_queue_drained", rd_q.size(), 0);
        check("final_found", found_out, m_found);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
